// File: rtl/mem_master.sv
// mem_master: initiator for the on-chip data RAM.
// Clears the array after reset, then serves one valid/ready request per cycle.
module mem_master #(
    parameter int              ADDR_W     = 9,
    parameter int              DATA_W     = 8,
    parameter int              INIT_EN    = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE = 8'h00
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_init_done,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_re,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;

    logic                fwd_v;
    logic [ADDR_W-1:0]   fwd_addr;
    logic [DATA_W-1:0]   fwd_data;

    logic                rd_v;
    logic                rd_hit;
    logic [DATA_W-1:0]   rd_fdata;
    logic [DATA_W-1:0]   rdata_q;

    logic                rd_acc;
    logic                hit;
    logic [DATA_W-1:0]   rsp_data;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        o_req_ready = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_re    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        rd_acc      = 1'b0;
        if (i_nrst) begin
            unique case (state_q)
                ST_INIT: begin
                    o_mem_we    = 1'b1;
                    o_mem_addr  = cnt_q;
                    o_mem_wdata = INIT_VALUE;
                    // counter parks at all ones; the state change ends the sweep
                    if (cnt_q == '1) state_d = ST_RUN;
                    else             cnt_d   = cnt_q + ADDR_W'(1);
                end
                ST_RUN: begin
                    o_req_ready = 1'b1;
                    if (i_req_valid) begin
                        o_mem_addr = i_req_addr;
                        if (i_req_we) begin
                            o_mem_we    = 1'b1;
                            o_mem_wdata = i_req_wdata;
                        end else begin
                            o_mem_re = 1'b1;
                            rd_acc   = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // RAM writes land a cycle late, so a read right behind one must be forwarded
    assign hit = rd_acc && fwd_v && (fwd_addr == i_req_addr);

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state_q  <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
            cnt_q    <= '0;
            fwd_v    <= 1'b0;
            fwd_addr <= '0;
            fwd_data <= '0;
            rd_v     <= 1'b0;
            rd_hit   <= 1'b0;
            rd_fdata <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fwd_v   <= o_mem_we;
            if (o_mem_we) begin
                fwd_addr <= o_mem_addr;
                fwd_data <= o_mem_wdata;
            end
            rd_v   <= rd_acc;
            rd_hit <= hit;
            if (hit) rd_fdata <= fwd_data;
            if (rd_v) rdata_q <= rsp_data;
        end
    end

    assign rsp_data    = rd_hit ? rd_fdata : i_mem_rdata;
    assign o_rsp_valid = i_nrst && rd_v;
    assign o_rsp_rdata = !i_nrst ? '0 : (rd_v ? rsp_data : rdata_q);
    assign o_init_done = i_nrst && (state_q == ST_RUN);

endmodule

// File: doc/mem_master.md
# mem_master

Initiator for the 512x8 on-chip data RAM. It clears the whole array after reset, then serves a single valid/ready request port from the core, driving the RAM address/write/read strobes and returning read data one cycle later. It also forwards write data when a read hits the address written in the previous cycle, because RAM writes commit one cycle late.

## Interface
Parameters:
- ADDR_W, 9: RAM address width; the array depth is 2^ADDR_W.
- DATA_W, 8: data width.
- INIT_EN, 1: 1 runs the clear sweep after reset; 0 skips it.
- INIT_VALUE, 8'h00: value written to every location during the sweep.

Ports:
- i_clk  in  1  sole clock, rising edge.
- i_nrst  in  1  reset, synchronous, active-low.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  request accepted this cycle when high together with i_req_valid.
- i_req_we  in  1  1 = write, 0 = read.
- i_req_addr  in  ADDR_W  request address.
- i_req_wdata  in  DATA_W  write data.
- o_rsp_valid  out  1  read response valid, one-cycle pulse per read.
- o_rsp_rdata  out  DATA_W  read data, held until the next response.
- o_init_done  out  1  sweep finished; stays high until the next reset.
- o_mem_addr  out  ADDR_W  RAM address.
- o_mem_we  out  1  RAM write strobe.
- o_mem_wdata  out  DATA_W  RAM write data.
- o_mem_re  out  1  RAM read strobe.
- i_mem_rdata  in  DATA_W  RAM read data, valid the cycle after o_mem_re.

## Operation
- States: INIT and RUN. Reset enters INIT if INIT_EN=1, otherwise RUN.
- INIT:
  - init_cnt counts 0 to 2^ADDR_W-1, one step per cycle.
  - Each cycle: o_mem_we=1, o_mem_addr=init_cnt, o_mem_wdata=INIT_VALUE, o_mem_re=0, o_req_ready=0.
  - After the write with init_cnt = all ones, the block moves to RUN and sets o_init_done=1. The counter does not wrap.
- RUN:
  - o_req_ready=1 every cycle; one request is accepted per cycle with no stalls.
  - Accepted write: o_mem_we=1, with o_mem_addr and o_mem_wdata taken directly from the request in the same cycle. No response is produced.
  - Accepted read: o_mem_re=1 and o_mem_addr=i_req_addr in the same cycle. The next cycle gives o_rsp_valid=1.
    - o_rsp_rdata takes the forwarded data if there is a forward hit, otherwise i_mem_rdata.
- Memory outputs with no accepted request: o_mem_we=0, o_mem_re=0, o_mem_addr=0, o_mem_wdata=0. These outputs are combinational from state and request.
- Forwarding:
  - A forward register {fwd_v, fwd_addr, fwd_data} captures every RAM write issued, including sweep writes.
  - fwd_v clears one cycle after capture unless another write is issued.
  - Forward hit: a read accepted while fwd_v=1 and fwd_addr equals the read address. The read response then returns fwd_data.
  - The captured hit decision travels with the read to its response cycle.
- Reset while running:
  - All state clears: o_rsp_valid=0, fwd_v=0, init_cnt=0.
  - If INIT_EN=1 the sweep re-runs.
  - A read in flight is dropped and gets no response.
- Request inputs are ignored whenever o_req_ready=0.

## Timing
- Values while i_nrst=0 are the reset values: o_req_ready=0, o_rsp_valid=0, o_rsp_rdata=0, o_init_done=0, o_mem_we=0, o_mem_re=0, o_mem_addr=0, o_mem_wdata=0.
- INIT_EN=1: with reset released before edge 0, sweep writes occupy cycles 0 to 2^ADDR_W-1. o_init_done and o_req_ready rise at cycle 2^ADDR_W, which is 512 for the defaults.
- INIT_EN=0: o_init_done=1 and o_req_ready=1 from the first cycle after reset release.
- Read latency is exactly 1 cycle from accept to o_rsp_valid. Throughput is 1 request per cycle.
- A write issued in cycle N is visible through a RAM read issued in cycle N+2 or later. A read in cycle N+1 is served by forwarding.
- Back-to-back writes to the same address followed by a read: the newest write wins.

## Test plan
- Sweep: INIT_EN=1, INIT_VALUE=8'hA5, reset released at cycle 0 -> 512 writes to addresses 0..511, then o_init_done=1 at cycle 512. Reading 0, 255 and 511 each returns 8'hA5.
- Basic write and read: write 0x3C to address 0x1F0, idle 2 cycles, read 0x1F0 -> o_rsp_valid one cycle after accept with data 0x3C.
- Forward hit: write 0x77 to address 0x005 in cycle N, read 0x005 in cycle N+1 -> response at N+2 with data 0x77.
- Forward miss: write 0x77 to 0x005 in cycle N, read 0x006 in cycle N+1 -> response is the RAM data for 0x006, not 0x77.
- Sweep edge: INIT_EN=1, first RUN cycle reads address 511 -> data equals INIT_VALUE via forwarding.
- Reset mid-operation: assert i_nrst=0 in the cycle after a read accept -> no o_rsp_valid. After release, o_init_done=0 and the sweep restarts at address 0.
